// File: rtl/bi_test_controller_pkg.sv
// Shared types and constants for the bus-invert test controller slice:
// FSM state encoding, default sizing and valid-pipe stage indices.
package bi_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int NUM_WORDS_DEF = 2000;
  localparam int CNT_W_DEF     = 11;
  localparam int STAGES_DEF    = 4;

  localparam int STG_ENC = 0;
  localparam int STG_BUS = 1;
  localparam int STG_DEC = 2;

  // The compare stage is always the last valid bit, whatever the depth.
  function automatic int stg_cmp(input int stages);
    return stages - 1;
  endfunction

endpackage

// File: rtl/bi_test_controller_if.sv
// Control/status bundle between the test controller (master) and the
// bus-invert datapath plus its stimulus source (slave).
interface bi_test_controller_if
  import bi_test_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             inject_err;
  logic             isequal;
  logic             en_gen_data;
  logic             en_gen_err;
  logic             en_enc;
  logic             en_bus;
  logic             en_trans_count;
  logic             en_dec;
  logic             en_k_comp;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] err_count;
  logic             pass;

  modport master (
    input  start, inject_err, isequal,
    output en_gen_data, en_gen_err, en_enc, en_bus, en_trans_count,
           en_dec, en_k_comp, done, busy, err_count, pass
  );

  modport slave (
    output start, inject_err, isequal,
    input  en_gen_data, en_gen_err, en_enc, en_bus, en_trans_count,
           en_dec, en_k_comp, done, busy, err_count, pass
  );
endinterface

// File: rtl/bi_test_controller_valid_pipe.sv
// Valid shift register tracking which datapath stages hold a live word;
// bit 0 follows the issue strobe and each bit feeds the next.
module bi_stage_valid_pipe #(
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic [STAGES-1:0] v,
  output logic              any_valid
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value, giving a true shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else     v <= {v[STAGES-2:0], in_valid};
  end

  assign any_valid = |v;

endmodule

// File: rtl/bi_test_controller.sv
// Run controller for the bus-invert datapath: issues NUM_WORDS words,
// sequences stage enables through the valid pipe, and tallies mismatches.
module bi_test_controller
  import bi_test_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int STAGES    = STAGES_DEF
) (
  input logic                  clk,
  input logic                  rst,
  bi_test_controller_if.master bus
);

  localparam int               STG_CMP = stg_cmp(STAGES);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, next_state;
  logic [CNT_W-1:0]  issued, err_count;
  logic              issue, busy_q, done_q, pass_q, err_mode;
  logic              issue_d, busy_d, done_d, pass_d;
  logic              start_run;
  logic [STAGES-1:0] v;
  logic              any_valid;

  assign start_run = bus.start && (state == IDLE || state == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every variable written here gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, FINISH: if (start_run)       next_state = RUN;
      RUN:          if (issued == LAST)  next_state = DRAIN;
      DRAIN:        if (!any_valid)      next_state = FINISH;
      default:                           next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so each lands in
  // the same cycle as the state it belongs to.
  always_comb begin
    issue_d = (next_state == RUN);
    busy_d  = (next_state == RUN) || (next_state == DRAIN);
    done_d  = (state == DRAIN) && (next_state == FINISH);
    pass_d  = (next_state == FINISH) && (err_count == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_mode  <= 1'b0;
      issued    <= '0;
      err_count <= '0;
    end else begin
      issue  <= issue_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      if (start_run) begin
        issued    <= '0;
        err_count <= '0;
        err_mode  <= bus.inject_err;
      end else begin
        if (state == RUN) issued <= issued + 1'b1;
        if (v[STG_CMP] && !bus.isequal && err_count != CNT_MAX)
          err_count <= err_count + 1'b1;
      end
    end
  end

  bi_stage_valid_pipe #(.STAGES(STAGES)) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .v         (v),
    .any_valid (any_valid)
  );

  assign bus.en_gen_data    = issue;
  assign bus.en_enc         = v[STG_ENC];
  assign bus.en_bus         = v[STG_BUS];
  assign bus.en_trans_count = v[STG_BUS];
  assign bus.en_dec         = v[STG_DEC];
  assign bus.en_k_comp      = v[STG_CMP];
  assign bus.en_gen_err     = v[STG_BUS] & err_mode;
  assign bus.done           = done_q;
  assign bus.busy           = busy_q;
  assign bus.err_count      = err_count;
  assign bus.pass           = pass_q;

endmodule
